mdu_seq: RTL
============

# mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide unit in the execute stage. It accepts an M-extension operation from EX and runs an iterative shift-add multiply or restoring divide over XLEN cycles. It stalls the pipeline while busy and presents a registered result for one cycle when finished. It handles the signed/unsigned variants and the divide-by-zero and overflow special cases required by the ISA.

## Interface
- XLEN, 32, operand/result width; iteration count.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; priority over all inputs.
- start  in  1  EX holds a valid M-extension instruction; held high until done.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand; sampled only on capture.
- b  in  XLEN  rs2 operand; sampled only on capture.
- flush  in  1  EX flush (branch/jump); aborts the operation.
- stall  out  1  combinational: start & ~done; freezes PC/IF/ID/EX.
- busy  out  1  registered; high in MUL and DIV states.
- done  out  1  registered; high only in DONE state.
- result  out  XLEN  registered; valid while done=1, held until the next capture.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset -> IDLE, result=0, done=0, busy=0, counter=0.
- Capture: in IDLE with start=1 and flush=0, latch funct3, sign flags and absolute operands, and set counter=XLEN-1.
  - Signed a for MUL/MULH/MULHSU/DIV/REM.
  - Signed b for MULH/DIV/REM only.
- IDLE -> MUL for funct3[2]=0; IDLE -> DIV for funct3[2]=1. Fast path exception below.
- Fast path: IDLE -> DONE directly, result set on the capture edge.
  - Divide by zero: DIV/DIVU result=all ones; REM/REMU result=a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- MUL: 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
  - Product sign = a_neg ^ b_neg; negate the 2*XLEN value if set.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DIV: restoring, one quotient bit per cycle, MSB first.
  - Quotient sign = a_neg ^ b_neg; remainder sign = a_neg.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Counter decrements each MUL/DIV cycle. At counter==0, the sign fix-up is applied, result is registered, and the state goes to DONE.
- DONE -> IDLE unconditionally. start still high in DONE does not recapture; the next instruction enters EX on the same edge.
- flush=1 in any state -> IDLE next edge: done=0, result unchanged, no capture that cycle. flush has priority over start.
- reset mid-operation -> IDLE and reset values next edge; the partial result is discarded.
- Arithmetic is modulo 2^XLEN (result) or 2^(2*XLEN) (product). No exceptions are raised.

## Timing
- Cycle 0 = IDLE with start=1. Iterative path:
  - stall=1 in cycles 0..XLEN; busy=1 in cycles 1..XLEN.
  - done=1 and stall=0 in cycle XLEN+1 (cycle 33 at XLEN=32).
  - EX occupancy is XLEN+2 cycles.
- Fast path: stall=1 in cycle 0, done=1 in cycle 1; EX occupancy 2 cycles.
- done is a single-cycle pulse per completed operation.
- Back-to-back: a start in the cycle after DONE (IDLE) captures normally. There is no dead cycle beyond the DONE->IDLE return.
- a, b and funct3 may change after cycle 0 without affecting the result.

## Test plan
- Reset, then MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done only in cycle 33, stall high in cycles 0..32.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, both with done in cycle 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1.
- MUL started, then flush in cycle 10 -> IDLE in cycle 11, done never asserted, result holds the prior value. A new start in cycle 11 completes correctly in cycle 44.
- DIV started, then reset in cycle 20 -> all outputs at reset values in cycle 21. Back-to-back MUL then DIVU completes both with the correct results.

Source files
------------

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - RV32M multi-cycle multiply/divide sequencer
// Purpose: runs shift-add multiply or restoring divide over XLEN cycles,
//          with divide-by-zero and signed-overflow results resolved on capture.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, funct3   M-extension request from EX and its operation select
//   a, b            rs1/rs2 operands, sampled only on capture
//   flush           aborts the current operation
//   stall           start & ~done, freezes the front of the pipeline
//   busy, done      iterating / result-valid pulse
//   result          registered result, held until the next capture
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  // MUL: {partial high, multiplier shifting out}. DIV: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // MUL: multiplicand. DIV: divisor.
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg_c, b_neg_c;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // MUL low half is sign-agnostic, so flagging a as signed there is harmless.
  assign a_signed = ~funct3[2] ? (funct3[1:0] != 2'b11) : ~funct3[0];
  assign b_signed = ~funct3[2] ? (funct3[1:0] == 2'b01) : ~funct3[0];
  assign a_neg_c  = a_signed & a[XLEN-1];
  assign b_neg_c  = b_signed & b[XLEN-1];
  assign abs_a    = a_neg_c ? -a : a;
  assign abs_b    = b_neg_c ? -b : b;

  assign div_zero = (b == '0);
  assign div_ovf  = ~funct3[0] & (a == MIN_NEG) & (b == '1);
  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = funct3[1] ? a : '1;
    else          fast_res = funct3[1] ? '0 : MIN_NEG;
  end

  // Add multiplicand into the high half when the current multiplier bit is set,
  // then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fix  = (a_neg_q ^ b_neg_q) ? -mul_next : mul_next;

  // Shift the next dividend bit into the remainder and subtract if it fits.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};
  assign quo_fix   = (a_neg_q ^ b_neg_q) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix   = a_neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f3_d    = funct3;
            a_neg_d = a_neg_c;
            b_neg_d = b_neg_c;
            cnt_d   = CNT_INIT;
            if (funct3[2] && (div_zero || div_ovf)) begin
              state_d  = S_DONE;
              result_d = fast_res;
            end else if (funct3[2]) begin
              state_d = S_DIV;
              acc_d   = {{XLEN{1'b0}}, abs_a};
              opb_d   = abs_b;
            end else begin
              state_d = S_MUL;
              acc_d   = {{XLEN{1'b0}}, abs_b};
              opb_d   = abs_a;
            end
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = (f3_q == 3'b000) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DIV: begin
          acc_d = div_next;
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = f3_q[1] ? rem_fix : quo_fix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign stall  = start & ~done;
  assign result = result_q;

endmodule
